// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared state encoding and sizing helper for the fft stream controller
package fft_ctrl_pkg;

  typedef enum logic [2:0] {LOAD, START, RUN, CAPTURE, UNLOAD} fft_ctrl_state_t;

  // Bits needed to count 0..value-1; expects value >= 2.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_buf.sv
// rtl/fft_out_buf.sv - result buffer: N words of 2*width, sync write, comb read
module fft_out_buf #(
  parameter int DW  = 32,
  parameter int N_2 = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           we,
  input  logic [N_2-1:0] wr_adr,
  input  logic [DW-1:0]  wr_data,
  input  logic [N_2-1:0] rd_adr,
  output logic [DW-1:0]  rd_data
);

  logic [DW-1:0] mem [2**N_2];

  // Reset clears the array so an aborted frame leaves no stale bins behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**N_2; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_adr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_adr];

endmodule

// File: rtl/fft_stream_ctrl.sv
// rtl/fft_stream_ctrl.sv - stream load / start / capture / replay sequencer around the fft core
// Optional: FFT_CTRL_STATS_EN adds frame_cnt and last_latency outputs.
module fft_stream_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int width   = 16,
  parameter int N_2     = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [width-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*width-1:0] out_data,
  output logic               out_last,
  output logic               busy,
  output logic               err_timeout,
  output logic               fft_load,
  output logic               fft_start,
  output logic [N_2-1:0]     fft_rd_adr,
  output logic [width-1:0]   fft_rd,
  input  logic [2*width-1:0] fft_wd,
  input  logic               fft_done
`ifdef FFT_CTRL_STATS_EN
  ,
  output logic [31:0]        frame_cnt,
  output logic [31:0]        last_latency
`endif
);

  localparam int N    = 2**N_2;
  localparam int WD_W = clog2(TIMEOUT);
  localparam logic [N_2-1:0]  LAST   = N_2'(N - 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT - 1);

  fft_ctrl_state_t state;
  logic [N_2-1:0]  ld_cnt;
  logic [N_2-1:0]  cap_cnt;
  logic [N_2-1:0]  ul_cnt;
  logic [WD_W-1:0] wdog;
  logic            cap_we;

  assign in_ready   = (state == LOAD);
  assign fft_load   = in_ready && in_valid;
  assign fft_rd_adr = ld_cnt;
  assign fft_rd     = in_data;
  assign fft_start  = (state == START);
  assign busy       = (state != LOAD);
  assign out_valid  = (state == UNLOAD);
  assign out_last   = out_valid && (ul_cnt == LAST);
  assign cap_we     = ((state == RUN) || (state == CAPTURE)) && fft_done;

  fft_out_buf #(
    .DW  (2*width),
    .N_2 (N_2)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .we      (cap_we),
    .wr_adr  (cap_cnt),
    .wr_data (fft_wd),
    .rd_adr  (ul_cnt),
    .rd_data (out_data)
  );

  // wdog equals the number of cycles since START, so it doubles as the latency measure.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      ld_cnt      <= '0;
      cap_cnt     <= '0;
      ul_cnt      <= '0;
      wdog        <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        LOAD: begin
          if (in_valid) begin
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt == LAST) begin
              wdog  <= '0;
              state <= START;
            end
          end
        end
        START: begin
          wdog  <= wdog + 1'b1;
          state <= RUN;
        end
        RUN: begin
          if (fft_done) begin
            cap_cnt <= cap_cnt + 1'b1;
            state   <= CAPTURE;
          end else if (wdog == WD_LIM) begin
            err_timeout <= 1'b1;
            state       <= LOAD;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        CAPTURE: begin
          if (fft_done) begin
            cap_cnt <= cap_cnt + 1'b1;
            if (cap_cnt == LAST) state <= UNLOAD;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            ul_cnt <= ul_cnt + 1'b1;
            if (ul_cnt == LAST) state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef FFT_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt    <= '0;
      last_latency <= '0;
    end else begin
      if (state == UNLOAD && out_ready && ul_cnt == LAST) frame_cnt <= frame_cnt + 1;
      if (state == RUN && fft_done) last_latency <= 32'(wdog);
    end
  end
`endif

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// tb/tb_fft_stream_ctrl.sv - directed bench for fft_stream_ctrl with a delayed-done core stub
module tb_fft_stream_ctrl;

  localparam int W       = 16;
  localparam int N_2     = 5;
  localparam int N       = 32;
  localparam int TIMEOUT = 1024;
  localparam int D       = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] out_data;
  logic           out_last;
  logic           busy;
  logic           err_timeout;
  logic           fft_load;
  logic           fft_start;
  logic [N_2-1:0] fft_rd_adr;
  logic [W-1:0]   fft_rd;
  logic [2*W-1:0] fft_wd = '0;
  logic           fft_done = 1'b0;

  int errors = 0;
  int checks = 0;

  fft_stream_ctrl #(.width(W), .N_2(N_2), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .err_timeout (err_timeout),
    .fft_load    (fft_load),
    .fft_start   (fft_start),
    .fft_rd_adr  (fft_rd_adr),
    .fft_rd      (fft_rd),
    .fft_wd      (fft_wd),
    .fft_done    (fft_done)
  );

  always #5 clk = ~clk;

  // Core stub: done held for N cycles starting D cycles after start, wd = {k, ~k}.
  bit stub_en = 1'b1;
  bit st_act = 1'b0;
  int st_cnt = 0;
  always @(negedge clk) begin
    logic [15:0] kk;
    if (fft_start) begin
      st_cnt = 0;
      st_act = 1'b1;
    end else if (st_act) begin
      st_cnt++;
    end
    if (st_act && stub_en && st_cnt >= D && st_cnt < D + N) begin
      kk = 16'(st_cnt - D);
      fft_done = 1'b1;
      fft_wd = {kk, ~kk};
    end else begin
      fft_done = 1'b0;
    end
    if (st_cnt >= D + N) st_act = 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bin_word(input int k);
    logic [15:0] a;
    a = 16'(k);
    return {a, ~a};
  endfunction

  task automatic feed_contig(input int base);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'(base + k);
      #1;
      chk("load_en", fft_load, 1);
      chk("load_adr", fft_rd_adr, k);
      chk("load_rd", fft_rd, 16'(base + k));
      chk("no_early_start", fft_start, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("start_pulse", fft_start, 1);
  endtask

  task automatic unload(input int stall_bin, input int reset_bin);
    int waited;
    waited = 0;
    out_ready = 1'b1;
    while (!out_valid && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
      if (waited == 1) chk("start_one_cycle", fft_start, 0);
    end
    chk("first_out_latency", waited, D + N);
    for (int k = 0; k < N; k++) begin
      if (k == stall_bin) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, bin_word(k));
          chk("stall_last", out_last, 0);
          @(negedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      chk("bin_valid", out_valid, 1);
      chk("bin_data", out_data, bin_word(k));
      chk("bin_last", out_last, (k == N - 1));
      if (k == reset_bin) begin
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    int loads;
    int n;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_fft_start", fft_start, 0);
    chk("rst_fft_load", fft_load, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    feed_contig(0);
    unload(-1, -1);

    // Gappy input: accept on even cycles only.
    loads = 0;
    for (int i = 0; i < 2*N - 1; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      in_data  = 16'(500 + i / 2);
      #1;
      chk("gap_no_start", fft_start, 0);
      if (in_valid) begin
        loads++;
        chk("gap_load", fft_load, 1);
        chk("gap_adr", fft_rd_adr, i / 2);
      end else begin
        chk("gap_noload", fft_load, 0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("gap_load_count", loads, N);
    chk("gap_start", fft_start, 1);
    unload(7, -1);

    stub_en = 1'b0;
    feed_contig(100);
    n = 0;
    while (!err_timeout && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("timeout_cycles", n, TIMEOUT);
    chk("timeout_busy", busy, 0);
    chk("timeout_in_ready", in_ready, 1);
    @(negedge clk);
    #1;
    chk("timeout_pulse_1cyc", err_timeout, 0);
    stub_en = 1'b1;

    feed_contig(200);
    unload(-1, 12);
    feed_contig(300);
    unload(-1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "bench time limit");
  end

endmodule
